// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit carry-select slice per stage,
// a global advance enable for backpressure, and registered sum/carry/overflow outputs.
module pipelined_csel_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_sum,
   output logic             o_out_cout,
   output logic             o_out_ovf
);

   localparam int NBLK = (BLOCK >= 1) ? (WIDTH / BLOCK) : 1;

   if (BLOCK < 1) begin : g_bad_block
      $error("pipelined_csel_adder: BLOCK must be >= 1");
   end else if (WIDTH % BLOCK != 0) begin : g_bad_split
      $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK");
   end

   // Node s feeds stage s; node 0 is the conditioned input, node s+1 is stage s's register.
   logic             w_v    [NBLK+1];
   logic             w_c    [NBLK+1];
   logic [WIDTH-1:0] w_sum  [NBLK+1];
   logic             w_amsb [NBLK+1];
   logic             w_bmsb [NBLK+1];
   logic [WIDTH-1:0] w_a    [NBLK];
   logic [WIDTH-1:0] w_b    [NBLK];

   logic [WIDTH-1:0] w_b_eff;
   logic             w_adv;

   assign w_b_eff   = i_sub ? ~i_b : i_b;
   assign w_v[0]    = i_in_valid;
   assign w_c[0]    = i_sub ? ~i_cin : i_cin;
   assign w_sum[0]  = '0;
   assign w_a[0]    = i_a;
   assign w_b[0]    = w_b_eff;
   assign w_amsb[0] = i_a[WIDTH-1];
   assign w_bmsb[0] = w_b_eff[WIDTH-1];

   assign w_adv      = !o_out_valid || i_out_ready;
   assign o_in_ready = w_adv;

   for (genvar s = 0; s < NBLK; s++) begin : g_stg
      logic             r_v;
      logic             r_c;
      logic             r_amsb;
      logic             r_bmsb;
      logic [WIDTH-1:0] r_sum;
      logic [BLOCK:0]   w_sum0;
      logic [BLOCK:0]   w_sum1;
      logic [BLOCK:0]   w_sel;

      assign w_sum0 = {1'b0, w_a[s][s*BLOCK +: BLOCK]} + {1'b0, w_b[s][s*BLOCK +: BLOCK]};
      assign w_sum1 = {1'b0, w_a[s][s*BLOCK +: BLOCK]} + {1'b0, w_b[s][s*BLOCK +: BLOCK]}
                    + (BLOCK+1)'(1);
      assign w_sel  = w_c[s] ? w_sum1 : w_sum0;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_v    <= 1'b0;
            r_c    <= 1'b0;
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_sum  <= '0;
         end else if (w_adv) begin
            r_v    <= w_v[s];
            r_c    <= w_sel[BLOCK];
            r_amsb <= w_amsb[s];
            r_bmsb <= w_bmsb[s];
            r_sum  <= w_sum[s];
            r_sum[s*BLOCK +: BLOCK] <= w_sel[BLOCK-1:0];
         end
      end

      assign w_v[s+1]    = r_v;
      assign w_c[s+1]    = r_c;
      assign w_sum[s+1]  = r_sum;
      assign w_amsb[s+1] = r_amsb;
      assign w_bmsb[s+1] = r_bmsb;

      // Operands only travel on while some block is still unresolved.
      if (s < NBLK-1) begin : g_opnd
         logic [WIDTH-1:0] r_a;
         logic [WIDTH-1:0] r_b;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_a[s];
               r_b <= w_b[s];
            end
         end

         assign w_a[s+1] = r_a;
         assign w_b[s+1] = r_b;
      end
   end

   assign o_out_valid = w_v[NBLK];
   assign o_out_sum   = w_sum[NBLK];
   assign o_out_cout  = w_c[NBLK];
   assign o_out_ovf   = (w_amsb[NBLK] == w_bmsb[NBLK]) && (o_out_sum[WIDTH-1] != w_amsb[NBLK]);

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed bench for pipelined_csel_adder: a 16/4 instance for the hand-computed cases
// and an 8/2 instance for a scoreboarded sweep with random valid/ready gaps.
module tb_pipelined_csel_adder;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        c;
      logic        o;
   } vec_t;

   localparam vec_t ADD_V [3] = '{
      '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0}
   };
   localparam vec_t SUB_V [2] = '{
      '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
      '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1}
   };
   localparam logic [15:0] B2B_A [6] = '{16'h0001, 16'h1000, 16'h00FF, 16'hABCD, 16'h0F0F, 16'h8000};
   localparam logic [15:0] B2B_B [6] = '{16'h0001, 16'h0FFF, 16'h0001, 16'h1111, 16'hF0F0, 16'h8000};
   localparam logic [15:0] B2B_S [6] = '{16'h0002, 16'h1FFF, 16'h0100, 16'hBCDE, 16'hFFFF, 16'h0000};
   localparam logic [7:0]  VALS8 [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h10, 8'h3C, 8'h55,
                                          8'h7E, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hFE, 8'hFF};

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, out_cout, out_ovf;
   logic [15:0] a, b, out_sum;

   logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, out_cout8, out_ovf8;
   logic [7:0] a8, b8, out_sum8;

   int checks = 0;
   int errors = 0;

   pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_sum(out_sum), .o_out_cout(out_cout), .o_out_ovf(out_ovf)
   );

   pipelined_csel_adder #(.WIDTH(8), .BLOCK(2)) dut8 (
      .clk(clk), .reset_n(reset_n),
      .i_in_valid(in_valid8), .o_in_ready(in_ready8),
      .i_a(a8), .i_b(b8), .i_cin(cin8), .i_sub(sub8),
      .o_out_valid(out_valid8), .i_out_ready(out_ready8),
      .o_out_sum(out_sum8), .o_out_cout(out_cout8), .o_out_ovf(out_ovf8)
   );

   // Presents one item on an empty pipe, then samples one edge before and at the expected edge.
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                        input logic isub, output logic [15:0] s, output logic c,
                        output logic o, output logic early, output logic vld);
      @(negedge clk);
      a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      early = out_valid;
      @(negedge clk);
      vld = out_valid; s = out_sum; c = out_cout; o = out_ovf;
   endtask

   task automatic test_reset;
      out_ready = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_sum !== 16'h0) begin errors++; $display("FAIL reset_out_sum: got %h expected 0000", out_sum); end
      checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %b expected 0", out_cout); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %b expected 0", out_valid8); end
      out_ready = 1'b1;
   endtask

   task automatic test_add;
      logic [15:0] s;
      logic c, o, e, v;
      for (int i = 0; i < 3; i++) begin
         issue(ADD_V[i].a, ADD_V[i].b, ADD_V[i].cin, ADD_V[i].sub, s, c, o, e, v);
         checks++; if (e !== 1'b0) begin errors++; $display("FAIL add%0d_early_valid: got %b expected 0", i, e); end
         checks++; if (v !== 1'b1) begin errors++; $display("FAIL add%0d_valid: got %b expected 1", i, v); end
         checks++; if (s !== ADD_V[i].s) begin errors++; $display("FAIL add%0d_sum: got %h expected %h", i, s, ADD_V[i].s); end
         checks++; if (c !== ADD_V[i].c) begin errors++; $display("FAIL add%0d_cout: got %b expected %b", i, c, ADD_V[i].c); end
         checks++; if (o !== ADD_V[i].o) begin errors++; $display("FAIL add%0d_ovf: got %b expected %b", i, o, ADD_V[i].o); end
      end
   endtask

   task automatic test_sub;
      logic [15:0] s;
      logic c, o, e, v;
      for (int i = 0; i < 2; i++) begin
         issue(SUB_V[i].a, SUB_V[i].b, SUB_V[i].cin, SUB_V[i].sub, s, c, o, e, v);
         checks++; if (e !== 1'b0) begin errors++; $display("FAIL sub%0d_early_valid: got %b expected 0", i, e); end
         checks++; if (v !== 1'b1) begin errors++; $display("FAIL sub%0d_valid: got %b expected 1", i, v); end
         checks++; if (s !== SUB_V[i].s) begin errors++; $display("FAIL sub%0d_sum: got %h expected %h", i, s, SUB_V[i].s); end
         checks++; if (c !== SUB_V[i].c) begin errors++; $display("FAIL sub%0d_cout: got %b expected %b", i, c, SUB_V[i].c); end
         checks++; if (o !== SUB_V[i].o) begin errors++; $display("FAIL sub%0d_ovf: got %b expected %b", i, o, SUB_V[i].o); end
      end
   endtask

   task automatic test_back_to_back;
      int tx = 0;
      int rx = 0;
      int stall_left = 0;
      bit stall_done = 1'b0;
      logic [15:0] held = '0;
      for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
         @(negedge clk);
         if (out_valid && !stall_done) begin
            stall_left = 3; stall_done = 1'b1; held = out_sum;
         end
         out_ready = (stall_left == 0);
         in_valid  = (tx < 6);
         cin = 1'b0; sub = 1'b0;
         if (tx < 6) begin a = B2B_A[tx]; b = B2B_B[tx]; end
         #1;
         if (stall_left > 0) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready: got %b expected 0", in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid: got %b expected 1", out_valid); end
            checks++; if (out_sum !== held) begin errors++; $display("FAIL b2b_stall_sum_hold: got %h expected %h", out_sum, held); end
            stall_left--;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (out_sum !== B2B_S[rx]) begin errors++; $display("FAIL b2b_result%0d: got %h expected %h", rx, out_sum, B2B_S[rx]); end
            rx++;
         end
         if (in_valid && in_ready) tx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (rx != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", rx); end
      checks++; if (!stall_done) begin errors++; $display("FAIL b2b_stall_seen: got 0 expected 1"); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_result: got %b expected 0", out_valid); end
      end
   endtask

   task automatic test_reset_midflight;
      logic [15:0] s;
      logic c, o, e, v;
      out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 16'h0100 * 16'(i + 1); b = 16'h0011; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid: got %b expected 1", out_valid); end
      reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_async_drop: got %b expected 0", out_valid); end
      checks++; if (out_sum !== 16'h0) begin errors++; $display("FAIL rst_mid_sum_clear: got %h expected 0000", out_sum); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale: got %b expected 0", out_valid); end
      end
      issue(16'h2222, 16'h1111, 1'b0, 1'b0, s, c, o, e, v);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL rst_mid_early_valid: got %b expected 0", e); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL rst_mid_valid: got %b expected 1", v); end
      checks++; if (s !== 16'h3333) begin errors++; $display("FAIL rst_mid_sum: got %h expected 3333", s); end
   endtask

   task automatic test_sweep8;
      logic [9:0] exp_q [$];
      logic [9:0] exp_v;
      logic [8:0] full;
      logic [7:0] beff;
      logic       c0;
      int tx = 0;
      int rx = 0;
      int bad = 0;
      for (int cyc = 0; cyc < 20000 && rx < 1024; cyc++) begin
         @(negedge clk);
         out_ready8 = ($urandom_range(0, 3) != 0);
         in_valid8  = (tx < 1024) && ($urandom_range(0, 3) != 0);
         a8   = VALS8[tx % 16];
         b8   = VALS8[(tx / 16) % 16];
         cin8 = ((tx / 256) % 2) != 0;
         sub8 = (tx / 512) != 0;
         #1;
         if (in_ready8 !== (!out_valid8 || out_ready8)) begin
            checks++; errors++;
            $display("FAIL sweep8_in_ready: got %b expected %b", in_ready8, !out_valid8 || out_ready8);
         end
         if (out_valid8 && out_ready8) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL sweep8_spurious: got sum %h expected no result", out_sum8);
            end else begin
               exp_v = exp_q.pop_front();
               if ({out_ovf8, out_cout8, out_sum8} !== exp_v) begin
                  errors++; bad++;
                  if (bad <= 8)
                     $display("FAIL sweep8_result%0d: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                              rx, out_ovf8, out_cout8, out_sum8, exp_v[9], exp_v[8], exp_v[7:0]);
               end
            end
            rx++;
         end
         if (in_valid8 && in_ready8) begin
            beff = sub8 ? ~b8 : b8;
            c0   = sub8 ? ~cin8 : cin8;
            full = {1'b0, a8} + {1'b0, beff} + {8'h00, c0};
            exp_q.push_back({(a8[7] == beff[7]) && (full[7] != a8[7]), full});
            tx++;
         end
      end
      in_valid8 = 1'b0; out_ready8 = 1'b1;
      checks++; if (rx != 1024) begin errors++; $display("FAIL sweep8_count: got %0d expected 1024", rx); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sweep8_leftover: got %0d expected 0", exp_q.size()); end
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      reset_n = 1'b1;
      test_add();
      test_sub();
      test_back_to_back();
      test_reset_midflight();
      test_sweep8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

endmodule
